// File: rtl/ram_pkg.sv
// Definitions shared by the two-port RAM and its read-side streaming engine.
package ram_pkg;

  localparam int unsigned RamWidth = 32;
  localparam int unsigned RamDepth = 256;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } rd_stream_state_e;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry FIFO-ordered valid/ready output buffer; push is never refused.
// RAM_RD_STREAM_LAST_EN adds a per-entry last flag.
module stream_buf2
  import ram_pkg::*;
#(
  parameter int unsigned Width = RamWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
`ifdef RAM_RD_STREAM_LAST_EN
  input  logic             last_i,
  output logic             last_o,
`endif
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] data_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;
  logic             pop;

  assign valid_o = (occ_q != 2'd0);
  assign pop     = valid_o & ready_i;
  assign data_o  = data_q[rd_ptr_q];
  assign occ_o   = occ_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop};
    end
  end

`ifdef RAM_RD_STREAM_LAST_EN
  logic last_q [2];

  assign last_o = valid_o & last_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
    end else if (push_i) begin
      last_q[wr_ptr_q] <= last_i;
    end
  end
`endif

endmodule

// File: rtl/ram_rd_stream.sv
// Sequential RAM read engine feeding a valid/ready stream with backpressure.
// Define RAM_RD_STREAM_LAST_EN to drive m_last_o on the final word of each transfer.
module ram_rd_stream
  import ram_pkg::*;
#(
  parameter int unsigned Width = RamWidth,
  parameter int unsigned Depth = RamDepth,
  localparam int unsigned Aw = $clog2(Depth),
  localparam int unsigned Lw = Aw + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Aw-1:0]    base_i,
  input  logic [Lw-1:0]    len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             re_o,
  output logic [Aw-1:0]    raddr_o,
  input  logic [Width-1:0] rdata_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [Width-1:0] m_data_o,
  output logic             m_last_o
);

  rd_stream_state_e state_q;
  logic [Aw-1:0]    addr_q, raddr_q, addr_next;
  logic [Lw-1:0]    rem_q;
  logic             inflight_q, done_q;
  logic [1:0]       occ;
  logic             pop, issue;

  assign pop = m_valid_o & m_ready_i;
  // Words already buffered or in flight, after this cycle's pop, must leave room.
  assign issue = (state_q == StRun) && (rem_q != '0) &&
                 (({1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
  assign addr_next = (addr_q == Aw'(Depth - 1)) ? '0 : addr_q + Aw'(1);

  assign re_o    = issue;
  assign raddr_o = issue ? addr_q : raddr_q;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      raddr_q    <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        addr_q  <= addr_next;
        raddr_q <= addr_q;
        rem_q   <= rem_q - Lw'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StRun;
              addr_q  <= base_i;
              rem_q   <= len_i;
            end
          end
        end
        StRun: begin
          if (issue && rem_q == Lw'(1)) state_q <= StDrain;
        end
        StDrain: begin
          if (pop && occ == 2'd1 && !inflight_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RAM_RD_STREAM_LAST_EN
  logic last_inflight_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_inflight_q <= 1'b0;
    else         last_inflight_q <= issue && (rem_q == Lw'(1));
  end
`else
  assign m_last_o = 1'b0;
`endif

  stream_buf2 #(
    .Width(Width)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (inflight_q),
    .data_i (rdata_i),
`ifdef RAM_RD_STREAM_LAST_EN
    .last_i (last_inflight_q),
    .last_o (m_last_o),
`endif
    .ready_i(m_ready_i),
    .valid_o(m_valid_o),
    .data_o (m_data_o),
    .occ_o  (occ)
  );

endmodule
